// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer.
// - ALU control codes used to recognise a multiply request (and a
//   representative non-multiply code).
// - FSM state encoding for the sequencer.
// - Helper that sizes the step counter from the operand width.
package mul_sequencer_pkg;

  localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTL_MUL = 4'b1010;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_BUSY = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_state_e;

  // Counter must hold 0..XLEN-1 with one spare bit of headroom.
  function automatic int mul_cnt_w(input int xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add multiply datapath.
// Holds the multiplicand, multiplier and accumulator. On load the operands
// are captured and the accumulator cleared; on each step the multiplicand
// is conditionally added (gated by the multiplier LSB), then the
// multiplicand shifts left and the multiplier shifts right.
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   load, step           control from the sequencer FSM (load has priority)
//   mcand_in, mplier_in  operands captured on load
//   acc                  running product, low XLEN bits
//   mplier_zero          multiplier bits still to be consumed after the
//                        current step are all zero
module mul_shift_add_dp
  import mul_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  output logic [XLEN-1:0] acc,
  output logic            mplier_zero
);

  logic [XLEN-1:0] mcand_reg;
  logic [XLEN-1:0] mplier_reg;
  logic [XLEN-1:0] acc_reg;
  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] acc_next;

  // Partial product for this step: multiplicand masked by multiplier LSB.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  // Carry out of the top bit is dropped: only the low XLEN bits are kept.
  assign acc_next = acc_reg + addend;

  always_ff @(posedge clk) begin
    if (srst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
    end else if (load) begin
      mcand_reg  <= mcand_in;
      mplier_reg <= mplier_in;
      acc_reg    <= '0;
    end else if (step) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
    end
  end

  assign acc = acc_reg;

  // Looks at the multiplier as it will be after this step's shift, so the
  // FSM can leave BUSY on the same edge that consumes the last set bit.
  assign mplier_zero = (mplier_reg[XLEN-1:1] == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle integer multiply controller for the EX stage.
// Recognises a multiply request, stalls the pipeline while a radix-2
// shift-add datapath produces the low XLEN bits of rs1*rs2, then presents
// the product for exactly one unstalled cycle.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   op_valid_i          valid instruction in EX
//   ALUCtl_i            ALU control code; ALU_CTL_MUL requests a multiply
//   flush_i             aborts any multiply in flight
//   rs1_data_i          multiplicand
//   rs2_data_i          multiplier
//   stall_o             hold IF/ID/EX pipeline registers
//   busy_o              sequencer is in BUSY
//   result_o            low XLEN bits of the product (held between results)
//   result_valid_o      one-cycle pulse when result_o carries a new product
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            op_valid_i,
  input  logic [3:0]      ALUCtl_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] result_o,
  output logic            result_valid_o
);

  localparam int              CNT_W    = mul_cnt_w(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  mul_state_e       state_reg;
  mul_state_e       state_next;
  logic [CNT_W-1:0] count_reg;
  logic [XLEN-1:0]  result_reg;
  logic [XLEN-1:0]  acc;
  logic             mplier_zero;
  logic             dp_load;
  logic             dp_step;
  logic             req;
  logic             last_step;

  assign req = op_valid_i && (ALUCtl_i == ALU_CTL_MUL) && !flush_i;

  // Full-length run ends when the counter reaches its final step; with
  // early-out the run also ends once no multiplier bits remain.
  assign last_step = (count_reg == CNT_LAST) || ((EARLY_OUT != 0) && mplier_zero);

  mul_shift_add_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk        (clk_i),
    .srst       (rst_i),
    .load       (dp_load),
    .step       (dp_step),
    .mcand_in   (rs1_data_i),
    .mplier_in  (rs2_data_i),
    .acc        (acc),
    .mplier_zero(mplier_zero)
  );

  // State register, step counter and held result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= MUL_ST_IDLE;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (dp_load) begin
        count_reg <= '0;
      end else if (dp_step) begin
        count_reg <= count_reg + 1'b1;
      end
      // A flushed DONE never publishes its product.
      if ((state_reg == MUL_ST_DONE) && !flush_i) begin
        result_reg <= acc;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MUL_ST_IDLE: begin
        if (req) begin
          state_next = MUL_ST_BUSY;
        end
      end
      MUL_ST_BUSY: begin
        if (flush_i) begin
          state_next = MUL_ST_IDLE;
        end else if (last_step) begin
          state_next = MUL_ST_DONE;
        end
      end
      MUL_ST_DONE: begin
        // Same instruction is still in EX, so op_valid_i is not looked at.
        state_next = MUL_ST_IDLE;
      end
      default: begin
        state_next = MUL_ST_IDLE;
      end
    endcase
  end

  // Output and datapath-control logic.
  always_comb begin
    stall_o        = 1'b0;
    busy_o         = 1'b0;
    result_valid_o = 1'b0;
    result_o       = result_reg;
    dp_load        = 1'b0;
    dp_step        = 1'b0;
    case (state_reg)
      MUL_ST_IDLE: begin
        // Hold the multiply in EX from the very first cycle it appears.
        stall_o = req && !rst_i;
        dp_load = req;
      end
      MUL_ST_BUSY: begin
        stall_o = !rst_i;
        busy_o  = 1'b1;
        dp_step = 1'b1;
      end
      MUL_ST_DONE: begin
        // Stall drops so the pipeline consumes the product this cycle.
        if (!flush_i) begin
          result_valid_o = 1'b1;
          result_o       = acc;
        end
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            op_valid;
  logic [3:0]      alu_ctl;
  logic            flush;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;

  logic            stall0, busy0, valid0;
  logic [XLEN-1:0] result0;
  logic            stall1, busy1, valid1;
  logic [XLEN-1:0] result1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Last product each instance is known to have published.
  logic [XLEN-1:0] last0 = '0;
  logic [XLEN-1:0] last1 = '0;
  bit              known0 = 1'b1;
  bit              known1 = 1'b1;

  always #5 clk = ~clk;

  mul_sequencer #(.XLEN(XLEN), .EARLY_OUT(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .op_valid_i(op_valid), .ALUCtl_i(alu_ctl),
    .flush_i(flush), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .stall_o(stall0), .busy_o(busy0), .result_o(result0), .result_valid_o(valid0)
  );

  mul_sequencer #(.XLEN(XLEN), .EARLY_OUT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .op_valid_i(op_valid), .ALUCtl_i(alu_ctl),
    .flush_i(flush), .rs1_data_i(rs1), .rs2_data_i(rs2),
    .stall_o(stall1), .busy_o(busy1), .result_o(result1), .result_valid_o(valid1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: low XLEN bits of the true product.
  function automatic logic [XLEN-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    return p[XLEN-1:0];
  endfunction

  // Reference: cycle (request = 0) in which the result pulse appears.
  // Full-length: XLEN BUSY cycles. Early-out: one BUSY cycle per multiplier
  // bit up to and including the most significant set bit, minimum one.
  function automatic int ref_done_cycle(input logic [XLEN-1:0] b, input bit early);
    if (!early) return XLEN + 1;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (b[i]) return i + 2;
    end
    return 2;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      op_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  // One multiply issued for a single cycle; both instances observed.
  task automatic do_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int done0 = -1, done1 = -1, pulses0 = 0, pulses1 = 0, stalls0 = 0, stalls1 = 0;
    logic [XLEN-1:0] r0 = '0, r1 = '0, exp_p;
    int exp_d0, exp_d1;
    exp_p  = ref_mul(a, b);
    exp_d0 = ref_done_cycle(b, 1'b0);
    exp_d1 = ref_done_cycle(b, 1'b1);
    @(negedge clk);
    op_valid = 1'b1; alu_ctl = ALU_CTL_MUL; rs1 = a; rs2 = b;
    for (int c = 0; c <= XLEN + 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        op_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
      end
      #1;
      if (stall0) stalls0++;
      if (stall1) stalls1++;
      if (valid0) begin pulses0++; if (done0 < 0) begin done0 = c; r0 = result0; end end
      if (valid1) begin pulses1++; if (done1 < 0) begin done1 = c; r1 = result1; end end
    end
    check("res0", r0, exp_p);
    check("lat0", done0, exp_d0);
    check("stall0_cycles", stalls0, exp_d0);
    check("pulses0", pulses0, 1);
    check("hold0", result0, exp_p);
    check("res1", r1, exp_p);
    check("lat1", done1, exp_d1);
    check("stall1_cycles", stalls1, exp_d1);
    check("pulses1", pulses1, 1);
    check("hold1", result1, exp_p);
    last0 = exp_p; last1 = exp_p; known0 = 1'b1; known1 = 1'b1;
    $display("mul 0x%08h*0x%08h -> full 0x%08h @%0d, early 0x%08h @%0d (want 0x%08h @%0d/@%0d)",
             a, b, r0, done0, r1, done1, exp_p, exp_d0, exp_d1);
  endtask

  // Multiply aborted (or not) by a one-cycle flush at cycle f (f >= 1).
  task automatic run_flush(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int f);
    int pulses0 = 0, pulses1 = 0, d0, d1;
    logic busy0_after = 1'b0, busy1_after = 1'b0;
    logic [XLEN-1:0] exp_p;
    exp_p = ref_mul(a, b);
    d0 = ref_done_cycle(b, 1'b0);
    d1 = ref_done_cycle(b, 1'b1);
    @(negedge clk);
    op_valid = 1'b1; alu_ctl = ALU_CTL_MUL; rs1 = a; rs2 = b; flush = 1'b0;
    for (int c = 0; c <= XLEN + 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        op_valid = 1'b0;
        flush = (c == f);
      end
      #1;
      if (valid0) pulses0++;
      if (valid1) pulses1++;
      if (c == f + 1) begin busy0_after = busy0; busy1_after = busy1; end
    end
    // A flush on or before the DONE cycle suppresses the result.
    check("flush_pulses0", pulses0, (f > d0) ? 1 : 0);
    check("flush_pulses1", pulses1, (f > d1) ? 1 : 0);
    if (f < d0) begin
      check("flush_busy0", busy0_after, 1'b0);
      if (known0) check("flush_keep0", result0, last0);
    end else if (f == d0) begin
      known0 = 1'b0;
    end else begin
      last0 = exp_p;
    end
    if (f < d1) begin
      check("flush_busy1", busy1_after, 1'b0);
      if (known1) check("flush_keep1", result1, last1);
    end else if (f == d1) begin
      known1 = 1'b0;
    end else begin
      last1 = exp_p;
    end
    $display("flush at %0d of 0x%08h*0x%08h: pulses full %0d early %0d", f, a, b, pulses0, pulses1);
  endtask

  initial begin
    logic [XLEN-1:0] ra, rb;
    int p1c, p2c, np;
    logic [XLEN-1:0] p1v, p2v;
    bit switched;

    rst = 1'b1; op_valid = 1'b1; alu_ctl = ALU_CTL_MUL; flush = 1'b0; rs1 = 32'd1; rs2 = 32'd1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall0", stall0, 1'b0);
    check("rst_stall1", stall1, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_valid0", valid0, 1'b0);
    check("rst_result0", result0, '0);
    check("rst_result1", result1, '0);
    $display("reset: stall %0b/%0b busy %0b valid %0b result 0x%0h", stall0, stall1, busy0, valid0, result0);
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    idle_cycles(2);

    // Reset in the middle of a multiply.
    begin
      int pulses = 0;
      @(negedge clk);
      op_valid = 1'b1; alu_ctl = ALU_CTL_MUL; rs1 = 32'd7; rs2 = 32'd9;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        op_valid = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_busy0", busy0, 1'b0);
      check("midrst_stall0", stall0, 1'b0);
      check("midrst_valid0", valid0, 1'b0);
      check("midrst_result0", result0, '0);
      check("midrst_result1", result1, '0);
      for (int c = 0; c < XLEN + 4; c++) begin
        @(negedge clk);
        #1;
        if (valid0 || valid1) pulses++;
      end
      check("midrst_nopulse", pulses, 0);
      last0 = '0; last1 = '0;
      $display("reset mid-busy: pulses after reset %0d", pulses);
    end

    do_mul(32'd6, 32'd7);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_mul(32'h8000_0000, 32'd2);
    do_mul(32'd5, 32'd3);
    do_mul(32'd123, 32'd0);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_mul(ra, rb);
    end

    // Non-multiply operation must not stall or start the sequencer.
    @(negedge clk);
    op_valid = 1'b1; alu_ctl = ALU_CTL_ADD; rs1 = $urandom; rs2 = $urandom;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("nonmul_stall0", stall0, 1'b0);
      check("nonmul_stall1", stall1, 1'b0);
      if (c > 0) check("nonmul_busy0", busy0, 1'b0);
      $display("nonmul cycle %0d: stall %0b/%0b busy %0b", c, stall0, stall1, busy0);
      @(negedge clk);
    end
    op_valid = 1'b0;

    // Back-to-back: op_valid stays high; the pipeline advances when the
    // full-length instance pulses its result.
    p1c = -1; p2c = -1; np = 0; p1v = '0; p2v = '0; switched = 1'b0;
    op_valid = 1'b1; alu_ctl = ALU_CTL_MUL; rs1 = 32'd3; rs2 = 32'd4;
    for (int c = 0; c < 2 * XLEN + 10; c++) begin
      if (c > 0) @(negedge clk);
      if (np == 1 && !switched) begin rs1 = 32'd5; rs2 = 32'd6; switched = 1'b1; end
      if (np >= 2) op_valid = 1'b0;
      #1;
      if (valid0) begin
        np++;
        if (np == 1) begin p1c = c; p1v = result0; end
        if (np == 2) begin p2c = c; p2v = result0; end
      end
    end
    check("b2b_pulses", np, 2);
    check("b2b_val1", p1v, ref_mul(32'd3, 32'd4));
    check("b2b_cyc1", p1c, XLEN + 1);
    check("b2b_val2", p2v, ref_mul(32'd5, 32'd6));
    check("b2b_gap", p2c - p1c, XLEN + 2);
    $display("back-to-back: %0d @%0d, %0d @%0d", p1v, p1c, p2v, p2c);
    idle_cycles(XLEN + 4);

    do_mul($urandom, $urandom);
    run_flush($urandom, 32'h8000_0003, 10);
    run_flush($urandom, 32'h0000_00FF, 9);
    run_flush($urandom, 32'd3, XLEN + 1);
    do_mul(32'd11, 32'd13);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller that sequences integer multiply for the EX stage whenever ALU control decodes `ALU_CTL_MUL`.
- Runs a radix-2 shift-add multiply, one multiplier bit per cycle, and holds the pipeline with a stall while it works.
- Returns the low XLEN bits of the product, matching RISC-V `mul`.
- Sits beside the ALU. Stall goes to the hazard/pipeline-register enables; result is muxed onto the EX result bus.

Parameters:
- XLEN, 32, operand and result width.
- EARLY_OUT, 1, when 1, finish as soon as the remaining multiplier bits are all zero.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- op_valid_i  in  1  valid instruction present in EX
- ALUCtl_i  in  4  ALU control code from ALU_Control
- flush_i  in  1  EX flush (branch/exception); aborts any multiply
- rs1_data_i  in  XLEN  multiplicand
- rs2_data_i  in  XLEN  multiplier
- stall_o  out  1  hold IF/ID/EX pipeline registers
- busy_o  out  1  FSM in BUSY
- result_o  out  XLEN  low XLEN bits of rs1*rs2
- result_valid_o  out  1  result_o valid this cycle

Behaviour:
- Request: req = op_valid_i && (ALUCtl_i == `ALU_CTL_MUL) && !flush_i.
- Reset: rst_i samples high at a clock edge. Afterwards state=IDLE, count=0, acc=0, result_o=0, result_valid_o=0, busy_o=0.
  - stall_o is forced 0 while rst_i is high.
  - A reset mid-multiply discards all work; no result_valid_o follows.
- States (encoding in Const.v): IDLE, BUSY, DONE.
- IDLE:
  - stall_o = req (combinational), so the mul stays in EX.
  - On the edge with req: latch mcand=rs1_data_i and mplier=rs2_data_i, clear acc, count=0, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stall_o=1, busy_o=1.
  - Each edge: if mplier[0], acc <= acc + mcand (mod 2^XLEN). Then mcand <= mcand<<1, mplier <= mplier>>1, count++.
  - Go to DONE on the edge where count reaches XLEN-1, i.e. after XLEN BUSY cycles.
  - EARLY_OUT=1: if the shifted-in mplier becomes 0, go to DONE on that same edge.
  - Minimum BUSY length is 1 cycle, including when rs2=0.
- DONE:
  - Exactly one cycle. result_o=acc, result_valid_o=1, stall_o=0, so the pipeline advances and consumes the mul.
  - op_valid_i is ignored in DONE; it is the same instruction. Next edge goes to IDLE.
- Latency (EARLY_OUT=0): request first seen at cycle 0 → result_valid_o at cycle XLEN+1. Total stalled cycles = XLEN+1.
- result_o holds its last value after DONE until the next DONE or reset. result_valid_o is a 1-cycle pulse.
- flush_i in BUSY or DONE: next edge goes to IDLE; no result_valid_o pulse. flush_i wins over DONE.
  - In DONE, result_valid_o is gated off by flush_i in the same cycle.
- Sign handling: none required; the low XLEN bits are identical for signed and unsigned operands.
- Non-mul ALUCtl_i: no effect in any state; stall_o=0 in IDLE.
- Back-to-back muls: the second request is seen in IDLE one cycle after DONE, giving one bubble between results.

Decomposition:
- Const.v gains:
  - `MUL_ST_IDLE`/`MUL_ST_BUSY`/`MUL_ST_DONE` (2-bit)
  - `MUL_CNT_W` = clog2(XLEN)+1
  - reuse of the existing `ALU_CTL_MUL`
- One sub-module, mul_shift_add_dp: mcand/mplier/acc registers plus adder.
  - Controls: load, step. Status: mplier_zero.
  - The FSM and counter stay in mul_sequencer.

Test Plan:
- Reset mid-BUSY: rs1=7, rs2=9, assert rst_i at BUSY cycle 5 → all outputs 0 the next cycle, no result_valid_o pulse, IDLE accepts a new mul immediately.
- Basic (EARLY_OUT=0): rs1=6, rs2=7 → stall_o high cycles 0..32, result_valid_o pulse at cycle 33 with result_o=42, stall_o low that cycle.
- Wrap/sign: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result_o=0x00000001. rs1=0x80000000, rs2=2 → result_o=0.
- Early-out (EARLY_OUT=1): rs1=5, rs2=3 → BUSY 2 cycles, result_valid_o at cycle 3, result_o=15. rs2=0 → BUSY 1 cycle, result_o=0.
- Flush: request at cycle 0, flush_i at cycle 10 → IDLE at cycle 11, no result_valid_o, result_o unchanged. flush_i during DONE → result_valid_o stays 0.
- Non-mul and back-to-back: ALUCtl_i=`ALU_CTL_ADD` with op_valid_i=1 → stall_o=0, no state change. Two consecutive muls (3*4, 5*6) → pulses with 12 then 30, one idle cycle apart.
